// File: rtl/processor_control_pkg.sv
// Shared pipeline-control definitions: memory opcodes, sequencer state encoding
// and the per-stage control bundle with its RUN-state decode.
package processor_control_pkg;

    localparam logic [4:0] OPCODE_LOAD  = 5'b01000;
    localparam logic [4:0] OPCODE_STORE = 5'b00111;
    localparam int         OPCODE_MSB   = 31;
    localparam int         OPCODE_LSB   = 27;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_ERROR    = 2'd3
    } pcu_state_t;

    typedef struct packed {
        logic pc_enable;
        logic pc_select_branch;
        logic fd_enable;
        logic dx_enable;
        logic xm_enable;
        logic mw_enable;
        logic fd_flush;
        logic dx_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FREEZE = '0;
    localparam stage_ctrl_t CTRL_RUN    = '{
        pc_enable:        1'b1,
        pc_select_branch: 1'b0,
        fd_enable:        1'b1,
        dx_enable:        1'b1,
        xm_enable:        1'b1,
        mw_enable:        1'b1,
        fd_flush:         1'b0,
        dx_bubble:        1'b0
    };

    function automatic logic is_mem_opcode(input logic [31:0] instr);
        return (instr[OPCODE_MSB:OPCODE_LSB] == OPCODE_LOAD) ||
               (instr[OPCODE_MSB:OPCODE_LSB] == OPCODE_STORE);
    endfunction

    // A taken branch discards the decode instruction, so it masks any load-use hazard.
    function automatic stage_ctrl_t run_ctrl(input logic branch, input logic hazard);
        stage_ctrl_t c;
        c = CTRL_RUN;
        if (branch) begin
            c.pc_select_branch = 1'b1;
            c.fd_flush         = 1'b1;
            c.dx_bubble        = 1'b1;
        end else if (hazard) begin
            c.pc_enable = 1'b0;
            c.fd_enable = 1'b0;
            c.dx_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Event inputs and stage-control outputs of the pipeline sequencer.
interface pipeline_control_unit_if #(
    parameter int COUNTER_WIDTH = 16
);
    logic                     hazard_detected;
    logic                     branch_taken;
    logic                     dmem_request;
    logic                     dmem_ready;
    logic                     halt_request;
    logic                     pc_enable;
    logic                     pc_select_branch;
    logic                     fd_enable;
    logic                     dx_enable;
    logic                     xm_enable;
    logic                     mw_enable;
    logic                     fd_flush;
    logic                     dx_bubble;
    logic                     halted;
    logic                     mem_timeout;
    logic [COUNTER_WIDTH-1:0] stall_count;
    logic [COUNTER_WIDTH-1:0] flush_count;

    modport master (
        output hazard_detected, branch_taken, dmem_request, dmem_ready, halt_request,
        input  pc_enable, pc_select_branch, fd_enable, dx_enable, xm_enable, mw_enable,
        input  fd_flush, dx_bubble, halted, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  hazard_detected, branch_taken, dmem_request, dmem_ready, halt_request,
        output pc_enable, pc_select_branch, fd_enable, dx_enable, xm_enable, mw_enable,
        output fd_flush, dx_bubble, halted, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (increment && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer: per-stage enables, flush and bubble from hazard, branch,
// data-memory and halt events, with a halt/error state machine and perf counters.
module pipeline_control_unit
    import processor_control_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    pipeline_control_unit_if.slave  ctrl
);

    localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);

    pcu_state_t         r_state;
    pcu_state_t         w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    stage_ctrl_t        w_ctrl;
    logic               w_stall_inc;
    logic               w_flush_inc;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_ctrl       = CTRL_FREEZE;
        unique case (r_state)
            ST_RUN: begin
                if (ctrl.halt_request) begin
                    w_state_next = ST_HALTED;
                end else if (ctrl.dmem_request && !ctrl.dmem_ready) begin
                    w_state_next = ST_MEM_WAIT;
                    w_timer_next = TIMER_W'(1);
                end else begin
                    w_ctrl = run_ctrl(ctrl.branch_taken, ctrl.hazard_detected);
                end
            end
            ST_MEM_WAIT: begin
                // The completing cycle behaves like RUN so a held branch/hazard acts now.
                if (ctrl.dmem_ready) begin
                    w_ctrl       = run_ctrl(ctrl.branch_taken, ctrl.hazard_detected);
                    w_state_next = ST_RUN;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                    if (int'(r_timer) + 1 >= MEM_TIMEOUT) begin
                        w_state_next = ST_ERROR;
                    end
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    assign w_stall_inc = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !w_ctrl.pc_enable;
    assign w_flush_inc = w_ctrl.fd_flush;

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (w_stall_inc),
        .count     (ctrl.stall_count)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (w_flush_inc),
        .count     (ctrl.flush_count)
    );

    assign ctrl.pc_enable        = w_ctrl.pc_enable;
    assign ctrl.pc_select_branch = w_ctrl.pc_select_branch;
    assign ctrl.fd_enable        = w_ctrl.fd_enable;
    assign ctrl.dx_enable        = w_ctrl.dx_enable;
    assign ctrl.xm_enable        = w_ctrl.xm_enable;
    assign ctrl.mw_enable        = w_ctrl.mw_enable;
    assign ctrl.fd_flush         = w_ctrl.fd_flush;
    assign ctrl.dx_bubble        = w_ctrl.dx_bubble;
    assign ctrl.halted           = (r_state == ST_HALTED) || (r_state == ST_ERROR);
    assign ctrl.mem_timeout      = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-vector bench for pipeline_control_unit with 4-bit counters and a 4-cycle memory timeout.
module tb_pipeline_control_unit;

    localparam int CW = 4;

    // {pc_en, pc_sel_br, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, halted, mem_timeout}
    localparam logic [9:0] V_IDLE   = 10'b1011110000;
    localparam logic [9:0] V_HAZARD = 10'b0001110100;
    localparam logic [9:0] V_BRANCH = 10'b1111111100;
    localparam logic [9:0] V_FREEZE = 10'b0000000000;
    localparam logic [9:0] V_HALTED = 10'b0000000010;
    localparam logic [9:0] V_ERROR  = 10'b0000000011;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pipeline_control_unit_if #(.COUNTER_WIDTH(CW)) bus ();

    pipeline_control_unit #(.COUNTER_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clock = ~clock;

    logic [9:0] obs;
    assign obs = {bus.pc_enable, bus.pc_select_branch, bus.fd_enable, bus.dx_enable,
                  bus.xm_enable, bus.mw_enable, bus.fd_flush, bus.dx_bubble,
                  bus.halted, bus.mem_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic drive(input logic h, input logic b, input logic req, input logic rdy, input logic halt);
        @(negedge clock);
        bus.hazard_detected = h;
        bus.branch_taken    = b;
        bus.dmem_request    = req;
        bus.dmem_ready      = rdy;
        bus.halt_request    = halt;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.hazard_detected = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.dmem_request    = 1'b0;
        bus.dmem_ready      = 1'b0;
        bus.halt_request    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.hazard_detected = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.dmem_request    = 1'b0;
        bus.dmem_ready      = 1'b0;
        bus.halt_request    = 1'b0;

        // Reset state and idle running
        do_reset();
        check("reset_ctrl", 32'(obs), 32'(V_IDLE));
        check("reset_stall", 32'(bus.stall_count), 32'd0);
        check("reset_flush", 32'(bus.flush_count), 32'd0);
        repeat (5) idle();
        check("idle5_ctrl", 32'(obs), 32'(V_IDLE));
        check("idle5_stall", 32'(bus.stall_count), 32'd0);
        check("idle5_flush", 32'(bus.flush_count), 32'd0);

        // Single load-use hazard
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hazard_ctrl", 32'(obs), 32'(V_HAZARD));
        idle();
        check("hazard_after_ctrl", 32'(obs), 32'(V_IDLE));
        check("hazard_stall", 32'(bus.stall_count), 32'd1);

        // Branch masks a simultaneous hazard
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("br_hz_ctrl", 32'(obs), 32'(V_BRANCH));
        idle();
        check("br_hz_after_ctrl", 32'(obs), 32'(V_IDLE));
        check("br_hz_flush", 32'(bus.flush_count), 32'd1);
        check("br_hz_stall", 32'(bus.stall_count), 32'd0);

        // 3-cycle memory freeze with a held branch resolving on the ready cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("memwait_freeze%0d", i), 32'(obs), 32'(V_FREEZE));
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("memwait_ready_branch", 32'(obs), 32'(V_BRANCH));
        idle();
        check("memwait_back_run", 32'(obs), 32'(V_IDLE));
        check("memwait_stall", 32'(bus.stall_count), 32'd3);
        check("memwait_flush", 32'(bus.flush_count), 32'd1);

        // Held hazard acts on the ready cycle and counts as a stall
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("memhz_freeze", 32'(obs), 32'(V_FREEZE));
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("memhz_ready_hazard", 32'(obs), 32'(V_HAZARD));
        idle();
        check("memhz_stall", 32'(bus.stall_count), 32'd2);

        // Timeout into ERROR; halt is ignored while waiting
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("tmo_freeze0", 32'(obs), 32'(V_FREEZE));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("tmo_freeze1_halt", 32'(obs), 32'(V_FREEZE));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("tmo_freeze2", 32'(obs), 32'(V_FREEZE));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("tmo_freeze3", 32'(obs), 32'(V_FREEZE));
        idle();
        check("tmo_error", 32'(obs), 32'(V_ERROR));
        check("tmo_stall", 32'(bus.stall_count), 32'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("tmo_error_sticky", 32'(obs), 32'(V_ERROR));
        do_reset();
        check("tmo_reset_ctrl", 32'(obs), 32'(V_IDLE));
        check("tmo_reset_stall", 32'(bus.stall_count), 32'd0);

        // Asynchronous reset in the middle of a memory wait
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("async_pre_freeze", 32'(obs), 32'(V_FREEZE));
        reset = 1'b1;
        bus.dmem_request = 1'b0;
        #1;
        check("async_rst_ctrl", 32'(obs), 32'(V_IDLE));
        check("async_rst_stall", 32'(bus.stall_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Stall counter saturation, then halt with a pending branch
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0 || i == 19) check($sformatf("sat_hazard%0d", i), 32'(obs), 32'(V_HAZARD));
        end
        idle();
        check("sat_stall", 32'(bus.stall_count), 32'd15);
        check("sat_flush", 32'(bus.flush_count), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("halt_req_ctrl", 32'(obs), 32'(V_FREEZE));
        idle();
        check("halted_ctrl", 32'(obs), 32'(V_HALTED));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halted_sticky", 32'(obs), 32'(V_HALTED));
        idle();
        check("halted_flush", 32'(bus.flush_count), 32'd0);
        check("halted_stall", 32'(bus.stall_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central stall/flush sequencer for the five-stage pipeline. It combines the load-use stall request from the hazard detection unit, the taken-branch signal from execute, and the data-memory handshake from the memory stage. From these it drives per-stage register enables, flushes and bubbles, holds a halt/error state machine, and counts stall and flush cycles for performance readout.

## Interface
- COUNTER_WIDTH, 16, width of the stall and flush performance counters
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before the error state
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; returns all state to reset values
- hazard_detected  input  1  load-use hazard, decode vs execute
- branch_taken  input  1  execute-stage branch/jump resolved taken
- dmem_request  input  1  memory stage is issuing a load or store this cycle
- dmem_ready  input  1  data memory completes the current access this cycle
- halt_request  input  1  halt instruction is in writeback
- pc_enable  output  1  PC register load enable
- pc_select_branch  output  1  PC loads the branch target instead of PC+4
- fd_enable, dx_enable, xm_enable, mw_enable  output  1 each  pipeline register enables
- fd_flush  output  1  F/D register loads a NOP
- dx_bubble  output  1  D/X register loads a NOP
- halted  output  1  pipeline halted
- mem_timeout  output  1  sticky error flag
- stall_count  output  COUNTER_WIDTH  saturating count of stall cycles
- flush_count  output  COUNTER_WIDTH  saturating count of branch flushes

## Operation
- States: RUN, MEM_WAIT, HALTED, ERROR. Reset state is RUN.
- Outputs are combinational from the state and inputs. Counters and the wait timer are registered.
- Default RUN outputs (no events): all enables 1; pc_select_branch, fd_flush, dx_bubble, halted and mem_timeout all 0.
- Event priority in RUN, highest first: halt_request, memory wait, branch_taken, hazard_detected.
- halt_request in RUN:
  - next state HALTED; all enables 0 this cycle.
- dmem_request && !dmem_ready in RUN:
  - all enables 0 (full freeze), no flush, no bubble.
  - next state MEM_WAIT; wait timer loads 1.
- branch_taken (no freeze):
  - pc_select_branch=1, fd_flush=1, dx_bubble=1; all enables 1.
  - flush_count increments. hazard_detected is ignored because the decode instruction is discarded.
- hazard_detected (no freeze, no branch):
  - pc_enable=0, fd_enable=0, dx_bubble=1; xm_enable=1, mw_enable=1.
  - stall_count increments.
- MEM_WAIT:
  - all enables 0; the timer increments each cycle.
  - dmem_ready=1: outputs for this cycle are the RUN outputs evaluated on the current inputs, which lets a held branch_taken or hazard act now. Next state RUN.
  - timer reaches MEM_TIMEOUT with dmem_ready=0: next state ERROR.
  - halt_request is ignored in MEM_WAIT.
- HALTED and ERROR:
  - absorbing; all enables 0; halted=1 in both.
  - mem_timeout=1 in ERROR only.
  - Exit only through reset.
- stall_count increments on every cycle with pc_enable=0 in RUN or MEM_WAIT, including the dmem_ready cycle if it stalls.
- Both counters saturate at all-ones; they never wrap.

## Timing
- Zero-cycle latency from inputs to enable/flush outputs (same cycle).
- State, timer and counters update on the rising clock edge.
- Load-use stall lasts exactly one cycle per hazard; a second hazard on the next cycle stalls again.
- Branch penalty: exactly two squashed instructions (F/D and D/X) in one cycle.
- A memory freeze of N cycles with dmem_ready on cycle N+1 holds the pipeline for N cycles.
- Reset asserted mid-MEM_WAIT or mid-stall: next state RUN immediately; counters and timer go to 0; outputs return to RUN defaults.

## Structure
- Shared package processor_control_pkg holds:
  - opcode constants OPCODE_LOAD=5'b01000 and OPCODE_STORE=5'b00111, plus opcode field bounds [31:27];
  - the state encoding (2-bit enumerated type).
- One sub-module, saturating_counter (parameter WIDTH; ports clock, reset, increment, count), instantiated twice: stall and flush.
- hazard_detection_unit stays outside this block; its hazard_detected output feeds this block directly.

## Test plan
- Reset with no other events: enables all 1, halted=0, counters 0; after 5 idle cycles, counters still 0.
- hazard_detected=1 for one cycle: pc_enable=0, fd_enable=0, dx_bubble=1 that cycle only; stall_count becomes 1.
- branch_taken=1 and hazard_detected=1 together: pc_select_branch=1, fd_flush=1, dx_bubble=1, pc_enable=1; flush_count=1, stall_count=0.
- dmem_request=1 with dmem_ready low for 3 cycles, then high, and branch_taken held: enables 0 for 3 cycles, then the branch flush in the ready cycle; state back to RUN.
- MEM_TIMEOUT=4 with dmem_ready never asserted: ERROR after 4 wait cycles, mem_timeout=1 and halted=1. Asserting reset returns to RUN with counters 0.
- COUNTER_WIDTH=4 with 20 consecutive hazard cycles: stall_count saturates at 15. halt_request then moves to HALTED with halted=1 and all enables 0.
